// File: rtl/mux2_rr_arbiter_if.sv
// ============================================================================
// mux2_rr_arbiter_if : request/grant and data bundle for the shared 2:1 channel
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

interface mux2_rr_arbiter_if #(
  parameter int W = 8
);
  logic         req_a;
  logic         req_b;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         gnt_a;
  logic         gnt_b;
  logic         sel;
  logic [W-1:0] y;
  logic         y_valid;

  modport master (
    output req_a, req_b, a, b,
    input  gnt_a, gnt_b, sel, y, y_valid
  );

  modport slave (
    input  req_a, req_b, a, b,
    output gnt_a, gnt_b, sel, y, y_valid
  );
endinterface

`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
// ============================================================================
// mux2_rr_arbiter : round-robin owner of a shared 2:1 mux with hold-limit preemption
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module mux2_rr_arbiter #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4,
  parameter int CW       = 3
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  mux2_rr_arbiter_if.slave  bus
);

  // One bit per owner so the grants and select are plain flop outputs.
  localparam logic [1:0]    c_idle     = 2'b00;
  localparam logic [1:0]    c_own_a    = 2'b01;
  localparam logic [1:0]    c_own_b    = 2'b10;
  localparam bit            c_preempt  = (MAX_HOLD != 0);
  localparam logic [CW-1:0] c_hold_max = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          r_last_b;
  logic          w_last_b_nxt;
  logic [CW-1:0] r_hold;
  logic [CW-1:0] w_hold_nxt;
  logic [W-1:0]  r_y;
  logic          r_y_valid;
  logic [CW-1:0] w_hold_inc;

  assign w_hold_inc = (r_hold == c_hold_max) ? r_hold : r_hold + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_idle;
      r_last_b <= 1'b1;
      r_hold   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_last_b <= w_last_b_nxt;
      r_hold   <= w_hold_nxt;
    end
  end

  // Release of the owner is checked before the preemption limit.
  always_comb begin
    w_state_nxt  = r_state;
    w_last_b_nxt = r_last_b;
    w_hold_nxt   = '0;
    case (r_state)
      c_idle: begin
        if (bus.req_a && bus.req_b) begin
          w_state_nxt = r_last_b ? c_own_a : c_own_b;
        end else if (bus.req_a) begin
          w_state_nxt = c_own_a;
        end else if (bus.req_b) begin
          w_state_nxt = c_own_b;
        end
      end
      c_own_a: begin
        if (!bus.req_a) begin
          w_last_b_nxt = 1'b0;
          w_state_nxt  = bus.req_b ? c_own_b : c_idle;
        end else if (bus.req_b) begin
          if (c_preempt && (r_hold == c_hold_max)) begin
            w_last_b_nxt = 1'b0;
            w_state_nxt  = c_own_b;
          end else begin
            w_hold_nxt = w_hold_inc;
          end
        end
      end
      c_own_b: begin
        if (!bus.req_b) begin
          w_last_b_nxt = 1'b1;
          w_state_nxt  = bus.req_a ? c_own_a : c_idle;
        end else if (bus.req_a) begin
          if (c_preempt && (r_hold == c_hold_max)) begin
            w_last_b_nxt = 1'b1;
            w_state_nxt  = c_own_a;
          end else begin
            w_hold_nxt = w_hold_inc;
          end
        end
      end
      default: begin
        w_state_nxt = c_idle;
      end
    endcase
  end

  // y follows the owner one cycle behind the grant and drops on its release edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else if ((r_state == c_own_a) && bus.req_a) begin
      r_y       <= bus.a;
      r_y_valid <= 1'b1;
    end else if ((r_state == c_own_b) && bus.req_b) begin
      r_y       <= bus.b;
      r_y_valid <= 1'b1;
    end else begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end
  end

  always_comb begin
    bus.gnt_a   = r_state[0];
    bus.gnt_b   = r_state[1];
    bus.sel     = r_state[1];
    bus.y       = r_y;
    bus.y_valid = r_y_valid;
  end

endmodule

`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
// ============================================================================
// tb_mux2_rr_arbiter : directed vectors for the arbiter, MAX_HOLD=4 and MAX_HOLD=0 builds
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mux2_rr_arbiter;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_a = 1'b0;
  logic         req_b = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux2_rr_arbiter_if #(.W(W)) bus0 ();
  mux2_rr_arbiter_if #(.W(W)) bus1 ();

  assign bus0.req_a = req_a;
  assign bus0.req_b = req_b;
  assign bus0.a     = a;
  assign bus0.b     = b;
  assign bus1.req_a = req_a;
  assign bus1.req_b = req_b;
  assign bus1.a     = a;
  assign bus1.b     = b;

  mux2_rr_arbiter #(.W(W), .MAX_HOLD(4), .CW(3)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  mux2_rr_arbiter #(.W(W), .MAX_HOLD(0), .CW(3)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // Observed outputs packed as {gnt_a, gnt_b, sel, y, y_valid}
  logic [11:0] obs0;
  logic [11:0] obs1;
  assign obs0 = {bus0.gnt_a, bus0.gnt_b, bus0.sel, bus0.y, bus0.y_valid};
  assign obs1 = {bus1.gnt_a, bus1.gnt_b, bus1.sel, bus1.y, bus1.y_valid};

  typedef struct {
    logic         ra;
    logic         rb;
    logic [W-1:0] da;
    logic [W-1:0] db;
    logic [11:0]  exp;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [11:0] e(input logic ga, input logic gb, input logic s,
                                    input logic [7:0] yy, input logic v);
    return {ga, gb, s, yy, v};
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got {ga,gb,sel,y,v}=%h required=%h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Single requester, tie after an A release (B wins), handover B->A, lone B.
    vecs[0]  = '{1'b1, 1'b0, 8'h5A, 8'h00, e(1, 0, 0, 8'h00, 0)};
    vecs[1]  = '{1'b1, 1'b0, 8'h5A, 8'h00, e(1, 0, 0, 8'h5A, 1)};
    vecs[2]  = '{1'b1, 1'b0, 8'h5A, 8'h00, e(1, 0, 0, 8'h5A, 1)};
    vecs[3]  = '{1'b0, 1'b0, 8'h5A, 8'h00, e(0, 0, 0, 8'h00, 0)};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'h00, e(0, 0, 0, 8'h00, 0)};
    vecs[5]  = '{1'b1, 1'b1, 8'h11, 8'h22, e(0, 1, 1, 8'h00, 0)};
    vecs[6]  = '{1'b1, 1'b1, 8'h11, 8'h22, e(0, 1, 1, 8'h22, 1)};
    vecs[7]  = '{1'b1, 1'b0, 8'h11, 8'h22, e(1, 0, 0, 8'h00, 0)};
    vecs[8]  = '{1'b1, 1'b0, 8'h11, 8'h22, e(1, 0, 0, 8'h11, 1)};
    vecs[9]  = '{1'b0, 1'b0, 8'h11, 8'h22, e(0, 0, 0, 8'h00, 0)};
    vecs[10] = '{1'b0, 1'b1, 8'h11, 8'h33, e(0, 1, 1, 8'h00, 0)};
    vecs[11] = '{1'b0, 1'b1, 8'h11, 8'h33, e(0, 1, 1, 8'h33, 1)};
    vecs[12] = '{1'b0, 1'b0, 8'h11, 8'h33, e(0, 0, 0, 8'h00, 0)};

    #1 rst_n = 1'b0;

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 4; i++) begin
      req_a = 1'($urandom_range(0, 1));
      req_b = 1'($urandom_range(0, 1));
      a     = 8'($urandom);
      b     = 8'($urandom);
      tick();
      check("reset_dut0", obs0, 12'h000);
      check("reset_dut1", obs1, 12'h000);
    end

    req_a = 1'b0;
    req_b = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_dut0", obs0, 12'h000);
      check("idle_dut1", obs1, 12'h000);
    end

    for (int i = 0; i < 13; i++) begin
      req_a = vecs[i].ra;
      req_b = vecs[i].rb;
      a     = vecs[i].da;
      b     = vecs[i].db;
      tick();
      check($sformatf("vec%0d_dut0", i), obs0, vecs[i].exp);
      check($sformatf("vec%0d_dut1", i), obs1, vecs[i].exp);
    end

    // Fresh reset between edges: tie then goes to A, then 4/4 alternation.
    #2 rst_n = 1'b0;
    #1 check("rst2_dut0", obs0, 12'h000);
    rst_n = 1'b1;
    req_a = 1'b1;
    req_b = 1'b1;
    a     = 8'h11;
    b     = 8'h22;
    for (int n = 1; n <= 22; n++) begin
      logic        own_a;
      logic [7:0]  ey;
      tick();
      own_a = (((n - 1) / 4) % 2) == 0;
      ey    = (n == 1) ? 8'h00 : (((((n - 2) / 4) % 2) == 0) ? 8'h11 : 8'h22);
      check($sformatf("contend%0d_dut0", n), obs0,
            e(own_a, !own_a, !own_a, ey, (n != 1)));
      check($sformatf("nohold%0d_dut1", n), obs1,
            e(1, 0, 0, (n == 1) ? 8'h00 : 8'h11, (n != 1)));
    end

    // dut0 now owned by B with y valid; async reset must clear everything at once.
    #2 rst_n = 1'b0;
    #1 check("async_rst_dut0", obs0, 12'h000);
    check("async_rst_dut1", obs1, 12'h000);
    rst_n = 1'b1;
    tick();
    check("post_rst_tie_dut0", obs0, e(1, 0, 0, 8'h00, 0));
    check("post_rst_tie_dut1", obs1, e(1, 0, 0, 8'h00, 0));
    tick();
    check("post_rst_data_dut0", obs0, e(1, 0, 0, 8'h11, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
